// File: rtl/sorted_stream_reader.sv
// ============================================================================
//  Module   : sorted_stream_reader
//  Purpose  : Snapshots packed sorter data/address arrays and streams them
//             out one element per cycle under valid/ready flow control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sorted_stream_reader #(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             descending,
    input  logic [W*N-1:0]   sorted_data,
    input  logic [W*N-1:0]   sorted_addr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [W-1:0]     out_addr,
    output logic [7:0]       out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] c_ptr_zero = '0;
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [AW-1:0] c_ptr_last = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SNAP   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [W-1:0]    r_snap_data [N];
    logic [W-1:0]    r_snap_addr [N];
    logic            r_desc;
    logic [AW-1:0]   r_ptr;
    logic [W-1:0]    r_out_data;
    logic [W-1:0]    r_out_addr;
    logic [7:0]      r_out_index;

    logic [AW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_ptr_end;
    logic            w_at_end;
    logic            w_xfer;

    assign w_ptr_end  = r_desc ? c_ptr_zero : c_ptr_last;
    assign w_at_end   = (r_ptr == w_ptr_end);
    assign w_xfer     = (r_state == S_STREAM) && out_ready;
    assign w_ptr_next = r_desc ? (r_ptr - c_ptr_one) : (r_ptr + c_ptr_one);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_SNAP;
            S_SNAP:   w_state_next = S_STREAM;
            S_STREAM: if (w_xfer && w_at_end) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // The output registers always mirror the snapshot entry under r_ptr, so the
    // presented element stays put during backpressure and holds through IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_desc      <= 1'b0;
            r_ptr       <= c_ptr_zero;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_index <= '0;
            for (int i = 0; i < N; i++) begin
                r_snap_data[i] <= '0;
                r_snap_addr[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && start) begin
                for (int i = 0; i < N; i++) begin
                    r_snap_data[i] <= sorted_data[W*i +: W];
                    r_snap_addr[i] <= sorted_addr[W*i +: W];
                end
                r_desc <= descending;
                r_ptr  <= descending ? c_ptr_last : c_ptr_zero;
            end
            if (r_state == S_SNAP) begin
                r_out_data  <= r_snap_data[r_ptr];
                r_out_addr  <= r_snap_addr[r_ptr];
                r_out_index <= 8'(r_ptr);
            end
            // The final element never advances the pointer, so it cannot wrap.
            if (w_xfer && !w_at_end) begin
                r_ptr       <= w_ptr_next;
                r_out_data  <= r_snap_data[w_ptr_next];
                r_out_addr  <= r_snap_addr[w_ptr_next];
                r_out_index <= 8'(w_ptr_next);
            end
        end
    end

    assign out_valid = (r_state == S_STREAM);
    assign out_last  = (r_state == S_STREAM) && w_at_end;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_index = r_out_index;

endmodule

`default_nettype wire

// File: tb/tb_sorted_stream_reader.sv
// ============================================================================
//  Module   : tb_sorted_stream_reader
//  Purpose  : Table-driven and scoreboard bench for sorted_stream_reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sorted_stream_reader;

    localparam int N = 64;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             descending;
    logic [W*N-1:0]   sorted_data;
    logic [W*N-1:0]   sorted_addr;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [W-1:0]     out_addr;
    logic [7:0]       out_index;
    logic             out_last;
    logic             busy;
    logic             done;

    sorted_stream_reader #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .descending  (descending),
        .sorted_data (sorted_data),
        .sorted_addr (sorted_addr),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] addr;
        logic [7:0] index;
        logic       last;
    } elem_t;

    typedef struct {
        logic desc;
        int   ready_mode;
        int   data_mode;
        logic corrupt;
        int   exp_first_data;
        int   exp_first_addr;
        int   exp_first_index;
        int   exp_last_data;
        int   exp_done;
    } vec_t;

    elem_t q[$];
    int    done_q[$];
    int    rise_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    cyc     = 0;
    int    s_start = 0;
    int    xfer_count = 0;
    logic  prev_stall = 1'b0;
    logic  prev_valid = 1'b0;
    logic  first_pending = 1'b0;
    elem_t first_e;
    elem_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] elem_data(input int mode, input int i);
        return (mode == 0) ? 8'(i + 1) : 8'(i * 5 + 7);
    endfunction

    function automatic logic [7:0] elem_addr(input int mode, input int i);
        return (mode == 0) ? 8'(63 - i) : (8'(i) ^ 8'h55);
    endfunction

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    task automatic load_arrays(input int mode);
        for (int i = 0; i < N; i++) begin
            sorted_data[W*i +: W] = elem_data(mode, i);
            sorted_addr[W*i +: W] = elem_addr(mode, i);
        end
    endtask

    task automatic push_pass(input int mode, input logic desc);
        elem_t x;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = desc ? (N - 1 - k) : k;
            x.data  = elem_data(mode, idx);
            x.addr  = elem_addr(mode, idx);
            x.index = 8'(idx);
            x.last  = (k == N - 1);
            q.push_back(x);
        end
    endtask

    // Scoreboard: the head of the queue must be presented whenever valid is
    // high, and is retired only on an accepted transfer.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (done) done_q.push_back(cyc - s_start);
            if (out_valid && !prev_valid) rise_q.push_back(cyc - s_start);
            if (prev_stall) chk("stall_valid_held", out_valid, 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    chk("data", out_data, e.data);
                    chk("addr", out_addr, e.addr);
                    chk("index", out_index, e.index);
                    chk("last", out_last, e.last);
                    if (out_ready) begin
                        void'(q.pop_front());
                        xfer_count++;
                        if (first_pending) begin
                            first_e = e;
                            first_pending = 1'b0;
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
        end
    end

    task automatic run_pass(input vec_t v, input string tag);
        load_arrays(v.data_mode);
        q.delete();
        done_q.delete();
        rise_q.delete();
        push_pass(v.data_mode, v.desc);
        first_pending = 1'b1;
        start      = 1'b1;
        descending = v.desc;
        s_start    = cyc;
        out_ready  = rdy(v.ready_mode, 0);
        for (int c = 1; c < 400; c++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = rdy(v.ready_mode, c);
            if (v.corrupt && c == 3) begin
                sorted_data = '1;
                sorted_addr = '1;
                descending  = ~v.desc;
            end
            if (done_q.size() > 0) break;
        end
        chk({tag, "_done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({tag, "_done_cycle"}, done_q[0], v.exp_done);
        if (rise_q.size() > 0) chk({tag, "_valid_rise"}, rise_q[0], 2);
        else chk({tag, "_valid_rise_seen"}, 0, 1);
        chk({tag, "_all_delivered"}, q.size(), 0);
        chk({tag, "_first_data"}, first_e.data, v.exp_first_data);
        chk({tag, "_first_addr"}, first_e.addr, v.exp_first_addr);
        chk({tag, "_first_index"}, first_e.index, v.exp_first_index);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_last"}, out_last, 0);
        chk({tag, "_idle_hold_data"}, out_data, v.exp_last_data);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 0, 0, 1'b0,  1, 63,  0,  64,  66};
        tbl[1] = '{1'b1, 0, 0, 1'b0, 64,  0, 63,   1,  66};
        tbl[2] = '{1'b0, 1, 0, 1'b0,  1, 63,  0,  64, 129};
        tbl[3] = '{1'b0, 0, 1, 1'b1,  7, 85,  0,  66,  66};
        tbl[4] = '{1'b1, 1, 1, 1'b0, 66, 106, 63,  7, 129};

        rst = 1'b0; start = 1'b0; descending = 1'b0; out_ready = 1'b0;
        sorted_data = '0; sorted_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        chk("reset_addr", out_addr, 0);
        chk("reset_index", out_index, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy_after_reset", busy, 0);

        for (int t = 0; t < 5; t++) run_pass(tbl[t], $sformatf("vec%0d", t));

        // Start during a pass is ignored; reset mid-stream aborts without done.
        load_arrays(0);
        q.delete(); done_q.delete(); rise_q.delete();
        push_pass(0, 1'b0);
        xfer_count = 0;
        start = 1'b1; descending = 1'b0; out_ready = 1'b1; s_start = cyc;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            start = (xfer_count == 10);
            if (xfer_count == 20) begin
                rst = 1'b0;
                break;
            end
        end
        chk("abort_reached_xfer20", xfer_count, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_index_cleared", out_index, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_still_idle", busy, 0);
        run_pass(tbl[0], "after_abort");

        // Back-to-back passes with start held high.
        load_arrays(0);
        q.delete(); done_q.delete(); rise_q.delete();
        push_pass(0, 1'b0);
        push_pass(0, 1'b0);
        start = 1'b1; descending = 1'b0; out_ready = 1'b1; s_start = cyc;
        for (int c = 1; c < 400; c++) begin
            @(posedge clk); #1;
            if (done_q.size() >= 2) break;
        end
        start = 1'b0;
        chk("b2b_done_count", done_q.size(), 2);
        if (done_q.size() >= 2) begin
            chk("b2b_done0", done_q[0], 66);
            chk("b2b_done1", done_q[1], 133);
        end
        chk("b2b_rise_count", rise_q.size(), 2);
        if (rise_q.size() >= 2) chk("b2b_second_rise", rise_q[1], 69);
        chk("b2b_all_delivered", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_back_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sorted_stream_reader.md
SORTED_STREAM_READER -- requirements
Module: sorted_stream_reader

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the number of entries in the packed arrays; legal range 2..256.
REQ-002 The block SHALL have parameter W, default 8, giving the width of each data and address entry.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous reset, active-low; sampled on the rising edge of clk.
REQ-005 Port start, input, 1 bit: request to snapshot the arrays and begin streaming.
REQ-006 Port descending, input, 1 bit: read order, sampled with start; 0 = entry 0 first, 1 = entry N-1 first.
REQ-007 Port sorted_data, input, W*N bits: packed sorter data; entry i occupies bits [W*i+W-1 : W*i].
REQ-008 Port sorted_addr, input, W*N bits: packed sorter addresses; same packing as sorted_data.
REQ-009 Port out_ready, input, 1 bit: downstream accepts the current element.
REQ-010 Port out_valid, output, 1 bit: out_data, out_addr, out_index and out_last are valid.
REQ-011 Port out_data, output, W bits: data of the current element.
REQ-012 Port out_addr, output, W bits: original address of the current element.
REQ-013 Port out_index, output, 8 bits: array position (0..N-1) of the current element.
REQ-014 Port out_last, output, 1 bit: the current element is the final element of the pass.
REQ-015 Port busy, output, 1 bit: high in SNAP, STREAM and DONE.
REQ-016 Port done, output, 1 bit: one-cycle pulse after the final transfer.

Function
REQ-017 The block SHALL implement the states IDLE, SNAP, STREAM and DONE.
REQ-018 IDLE->SNAP when start=1:
- Both packed arrays are captured into internal registers on the same edge.
- descending is latched on the same edge.
REQ-019 SNAP->STREAM unconditionally on the next edge; out_valid SHALL rise on the cycle STREAM is entered, 2 cycles after start is sampled.
REQ-020 After the snapshot, changes on sorted_data, sorted_addr or descending SHALL NOT affect the output of the current pass.
REQ-021 A transfer SHALL occur on each edge where out_valid=1 and out_ready=1.
- The element pointer advances on each transfer: +1 ascending, -1 descending.
- Throughput is 1 element per cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_addr, out_index and out_last SHALL hold stable and out_valid SHALL stay 1.
REQ-023 The pointer SHALL start at 0 (ascending) or N-1 (descending).
- out_last=1 exactly when the pointer is N-1 (ascending) or 0 (descending) and the block is in STREAM.
REQ-024 The pointer SHALL NOT wrap: the transfer of the last element moves the state STREAM->DONE and clears out_valid on that edge.
REQ-025 DONE SHALL last exactly one cycle, with done=1 and busy=1, then return to IDLE.
REQ-026 start SHALL be ignored in SNAP, STREAM and DONE; a start held through DONE SHALL begin a new pass from IDLE on the following edge.
REQ-027 Exactly N transfers SHALL occur per pass, in index order, with no element repeated or dropped.
REQ-028 In IDLE: out_valid=0, out_last=0, busy=0, done=0; out_data, out_addr and out_index hold their last values.

Reset
REQ-029 On an edge with rst=0, the state SHALL go to IDLE and the following SHALL be cleared to 0: pointer, snapshot registers, out_valid, out_data, out_addr, out_index, out_last, busy and done.
REQ-030 Reset SHALL take priority over start and over any transfer in progress; a pass aborted by reset produces no done pulse.
REQ-031 On the first edge after rst returns to 1, the block SHALL be in IDLE and able to accept start.

Verification
REQ-032 Ascending pass: N=64; sorted_data entry i=i+1, sorted_addr entry i=63-i; out_ready=1; start pulsed 1 cycle.
- Expect out_valid from start+2.
- Expect 64 consecutive transfers with (data, addr, index) = (i+1, 63-i, i).
- Expect out_last only on index 63, then done pulsed at start+66.
REQ-033 Descending pass: same arrays, descending=1.
- Expect the first element (64, 0, 63) and the last element (1, 63, 0) with out_last=1.
REQ-034 Backpressure: out_ready toggled 1,0,0,1 repeating.
- Expect outputs stable during stalls.
- Expect all 64 elements delivered, each exactly once, in order.
- Expect done only after index 63 is accepted.
REQ-035 Snapshot isolation: all input array entries changed to 8'hFF 3 cycles after start.
- Expect the streamed values to still equal the pre-start values.
REQ-036 Start while busy, then reset: start asserted at transfer 10.
- Expect no effect on the pass.
- rst=0 for 1 cycle at transfer 20: expect out_valid=0 and busy=0 on the next cycle, and no done pulse.
- A new start then streams from index 0.
REQ-037 Back-to-back: start held high continuously.
- Expect passes separated by exactly DONE + IDLE (2 cycles between the last transfer and the next SNAP).
